// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, data port and external asynchronous SRAM pins
// seen by sram_port_arbiter; slave = arbiter side, master = requesters and SRAM.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;
    logic              dm_stall;

    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_o;
    logic              sram_dq_oe;
    logic [31:0]       sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [3:0]        sram_be_n;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack, if_stall,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_ack, dm_stall,
        output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        input  sram_dq_i
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack, if_stall,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack, dm_stall,
        input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output sram_dq_i
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between the fetch and data ports with a multi-cycle
// read/write sequencer. Optional macro SRAM_ARB_RR_EN: round-robin instead of data-first priority.
module sram_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_e;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_dm_q, owner_dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              grant_dm;
    logic              unused_addr_bits;

`ifdef SRAM_ARB_RR_EN
    // Remembers who won the last grant; reset value 0 means the fetch port.
    logic last_dm_q, last_dm_d;

    assign grant_dm  = bus.dm_req && !(bus.if_req && last_dm_q);
    assign last_dm_d = (state_q == IDLE && (bus.dm_req || bus.if_req)) ? grant_dm : last_dm_q;

    always_ff @(posedge clk) begin
        if (rst) last_dm_q <= 1'b0;
        else     last_dm_q <= last_dm_d;
    end
`else
    assign grant_dm = bus.dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Strobes are set up here so they are already registered on the first RD/WR cycle.
                if (grant_dm) begin
                    owner_dm_d = 1'b1;
                    addr_d     = bus.dm_addr[ADDR_W+1:2];
                    be_n_d     = ~bus.dm_be;
                    ce_n_d     = 1'b0;
                    if (bus.dm_we) begin
                        state_d = WR;
                        we_n_d  = 1'b0;
                        dq_oe_d = 1'b1;
                        dq_o_d  = bus.dm_wdata;
                    end else begin
                        state_d = RD;
                        oe_n_d  = 1'b0;
                    end
                end else if (bus.if_req) begin
                    owner_dm_d = 1'b0;
                    addr_d     = bus.if_addr[ADDR_W+1:2];
                    be_n_d     = '0;
                    ce_n_d     = 1'b0;
                    oe_n_d     = 1'b0;
                    state_d    = RD;
                end
            end
            RD: begin
                if (cnt_q == WS) begin
                    if (owner_dm_q) begin
                        dm_rdata_d = bus.sram_dq_i;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.sram_dq_i;
                        if_ack_d   = 1'b1;
                    end
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = '1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR: begin
                if (cnt_q == WS) begin
                    we_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TURN: begin
                // Data was held through the recovery cycle; release the bus now.
                dq_oe_d  = 1'b0;
                be_n_d   = '1;
                dm_ack_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_dm_q <= 1'b0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_dm_q <= owner_dm_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
        end
    end

    // Byte-offset and above-SRAM address bits are deliberately ignored.
    assign unused_addr_bits = ^{bus.if_addr, bus.dm_addr};

    assign bus.sram_addr  = addr_q;
    assign bus.sram_dq_o  = dq_o_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_be_n  = be_n_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ack     = if_ack_q;
    assign bus.if_stall   = bus.if_req & ~if_ack_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.dm_ack     = dm_ack_q;
    assign bus.dm_stall   = bus.dm_req & ~dm_ack_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: pin-level SRAM model plus a transaction-level
// reference (shadow memory, latency formulas, arbitration order).
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    localparam int ADDR_W = 18;
    localparam int WS     = 1;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last_dm = 1'b0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus0 ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut  (.clk(clk), .rst(rst), .bus(bus));
    sram_port_arbiter #(.ADDR_W(ADDR_W), .WAIT_STATES(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Asynchronous SRAM behind the main DUT
    always_comb begin
        bus.sram_dq_i = 32'h0;
        if (!bus.sram_ce_n && !bus.sram_oe_n) bus.sram_dq_i = mem[bus.sram_addr[9:0]];
    end
    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n)
            for (int b = 0; b < 4; b++)
                if (!bus.sram_be_n[b]) mem[bus.sram_addr[9:0]][8*b +: 8] <= bus.sram_dq_o[8*b +: 8];
    end

    // Zero-wait-state DUT reads a pattern derived from the word address
    always_comb begin
        bus0.sram_dq_i = 32'h0;
        if (!bus0.sram_ce_n && !bus0.sram_oe_n) bus0.sram_dq_i = 32'hC0DE_0000 | 32'(bus0.sram_addr);
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus0.if_req = 0; bus0.if_addr = 0; bus0.dm_req = 0; bus0.dm_we = 0;
        bus0.dm_be = 0; bus0.dm_addr = 0; bus0.dm_wdata = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe} !== 8'b1111_1110) begin
            n_fail++;
            $display("FAIL reset_pins got ce/oe/we/be/oe=%b required 11111110",
                     {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe});
        end
        n_checks++;
        if (bus.sram_addr !== '0 || bus.sram_dq_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got addr=%h dq_o=%h required 0 0", bus.sram_addr, bus.sram_dq_o);
        end
        n_checks++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ports got if_rdata=%h dm_rdata=%h if_ack=%b dm_ack=%b required all 0",
                     bus.if_rdata, bus.dm_rdata, bus.if_ack, bus.dm_ack);
        end
        n_checks++;
        if (bus0.sram_ce_n !== 1'b1 || bus0.if_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut0 got ce_n=%b if_ack=%b required 1 0", bus0.sram_ce_n, bus0.if_ack);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0010;
        addrs[1] = 32'hFFF0_0012;   // high and byte bits must be ignored
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); bus.if_req = 1'b1; bus.if_addr = addrs[t];
            for (int cyc = 1; cyc <= WS + 3; cyc++) begin
                @(posedge clk); #1;
                n_checks++;
                if (cyc <= WS + 1) begin
                    if (bus.sram_addr !== ADDR_W'(4) || bus.sram_ce_n !== 1'b0 || bus.sram_oe_n !== 1'b0 ||
                        bus.if_stall !== 1'b1 || bus.if_ack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fetch_strobe cyc=%0d got addr=%h ce_n=%b oe_n=%b stall=%b ack=%b required 4 0 0 1 0",
                                 cyc, bus.sram_addr, bus.sram_ce_n, bus.sram_oe_n, bus.if_stall, bus.if_ack);
                    end
                end else if (cyc == WS + 2) begin
                    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h2402_000A || bus.if_stall !== 1'b0 ||
                        bus.sram_ce_n !== 1'b1) begin
                        n_fail++;
                        $display("FAIL fetch_ack cyc=%0d got ack=%b rdata=%h stall=%b ce_n=%b required 1 2402000a 0 1",
                                 cyc, bus.if_ack, bus.if_rdata, bus.if_stall, bus.sram_ce_n);
                    end
                    @(negedge clk); bus.if_req = 1'b0;
                end else begin
                    if (bus.if_ack !== 1'b0 || bus.if_rdata !== 32'h2402_000A) begin
                        n_fail++;
                        $display("FAIL fetch_hold got ack=%b rdata=%h required 0 2402000a", bus.if_ack, bus.if_rdata);
                    end
                end
            end
        end
        model_last_dm = 1'b0;
    endtask

    // One transaction (fetch, data, or both at once) checked cycle by cycle against the reference.
    task automatic run_txn(input bit do_if, input bit do_dm, input bit we, input logic [3:0] be,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        int len_if, len_dm, exp_if, exp_dm, last;
        bit dm_first;
        logic [31:0] exp_ird, exp_drd;
        exp_ird = 32'h0; exp_drd = 32'h0;
        len_if   = WS + 2;
        len_dm   = we ? WS + 3 : WS + 2;
        dm_first = do_dm && (!do_if || !RR || !model_last_dm);
        exp_if   = !do_if ? -1 : (do_dm && dm_first)  ? len_dm + len_if : len_if;
        exp_dm   = !do_dm ? -1 : (do_if && !dm_first) ? len_if + len_dm : len_dm;
        if (do_if && !dm_first) exp_ird = ref_mem[widx(ia)];
        if (do_dm) begin
            if (we) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[widx(da)][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_drd = ref_mem[widx(da)];
            end
        end
        if (do_if && dm_first) exp_ird = ref_mem[widx(ia)];
        if (do_if && do_dm) model_last_dm = !dm_first;
        else if (do_if || do_dm) model_last_dm = do_dm;
        last = (exp_if > exp_dm ? exp_if : exp_dm) + 1;

        @(negedge clk);
        bus.if_req = do_if; bus.if_addr = ia;
        bus.dm_req = do_dm; bus.dm_we = we; bus.dm_be = be; bus.dm_addr = da; bus.dm_wdata = wd;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.if_ack !== (cyc == exp_if) || bus.dm_ack !== (cyc == exp_dm) ||
                bus.if_stall !== (do_if && cyc < exp_if) || bus.dm_stall !== (do_dm && cyc < exp_dm)) begin
                n_fail++;
                $display("FAIL txn_handshake cyc=%0d got if_ack=%b dm_ack=%b if_stall=%b dm_stall=%b required ack at if=%0d dm=%0d",
                         cyc, bus.if_ack, bus.dm_ack, bus.if_stall, bus.dm_stall, exp_if, exp_dm);
            end
            if (do_if && cyc == exp_if) begin
                n_checks++;
                if (bus.if_rdata !== exp_ird) begin
                    n_fail++; $display("FAIL txn_if_rdata got %h required %h", bus.if_rdata, exp_ird);
                end
            end
            if (do_dm && !we && cyc == exp_dm) begin
                n_checks++;
                if (bus.dm_rdata !== exp_drd) begin
                    n_fail++; $display("FAIL txn_dm_rdata got %h required %h", bus.dm_rdata, exp_drd);
                end
            end
            @(negedge clk);
            if (cyc >= exp_if) bus.if_req = 1'b0;
            if (cyc >= exp_dm) bus.dm_req = 1'b0;
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'b0011; bus.dm_addr = 32'h20; bus.dm_wdata = 32'hDEAD_BEEF;
        for (int cyc = 1; cyc <= WS + 3; cyc++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cyc <= WS + 1) begin
                if (bus.sram_we_n !== 1'b0 || bus.sram_ce_n !== 1'b0 || bus.sram_oe_n !== 1'b1 ||
                    bus.sram_be_n !== 4'b1100 || bus.sram_dq_oe !== 1'b1 || bus.sram_addr !== ADDR_W'(8) ||
                    bus.sram_dq_o !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL write_strobe cyc=%0d got we_n=%b ce_n=%b oe_n=%b be_n=%b dq_oe=%b addr=%h dq=%h required 0 0 1 1100 1 8 deadbeef",
                             cyc, bus.sram_we_n, bus.sram_ce_n, bus.sram_oe_n, bus.sram_be_n, bus.sram_dq_oe,
                             bus.sram_addr, bus.sram_dq_o);
                end
            end else if (cyc == WS + 2) begin
                if (bus.sram_we_n !== 1'b1 || bus.sram_ce_n !== 1'b1 || bus.sram_dq_oe !== 1'b1 ||
                    bus.dm_ack !== 1'b0 || bus.dm_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_turn got we_n=%b ce_n=%b dq_oe=%b ack=%b stall=%b required 1 1 1 0 1",
                             bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe, bus.dm_ack, bus.dm_stall);
                end
            end else begin
                if (bus.dm_ack !== 1'b1 || bus.dm_stall !== 1'b0 || bus.sram_dq_oe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_ack got ack=%b stall=%b dq_oe=%b required 1 0 0",
                             bus.dm_ack, bus.dm_stall, bus.sram_dq_oe);
                end
                @(negedge clk); bus.dm_req = 1'b0;
            end
        end
        ref_mem[8][15:0] = 16'hBEEF;
        model_last_dm = 1'b1;
        run_txn(0, 1, 0, 4'hF, 32'h0, 32'h20, 32'h0);
    endtask

    task automatic test_priority();
        logic [31:0] ia, da;
        ia = 32'($urandom_range(0, 1023)) << 2;
        da = 32'($urandom_range(0, 1023)) << 2;
        run_txn(1, 1, 0, 4'hF, ia, da, 32'h0);
    endtask

    task automatic test_rr();
        int acks, last_cyc;
        bit exp_dm_win;
        logic [31:0] ia, da;
        ia = 32'h0000_0100; da = 32'h0000_0204;
        acks = 0; last_cyc = 0;
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = ia;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = da;
        for (int cyc = 1; cyc <= 100 && acks < 8; cyc++) begin
            @(posedge clk); #1;
            if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) begin
                exp_dm_win = RR ? !model_last_dm : 1'b1;
                n_checks++;
                if (bus.dm_ack !== exp_dm_win || bus.if_ack !== !exp_dm_win || cyc - last_cyc != WS + 2) begin
                    n_fail++;
                    $display("FAIL rr_grant n=%0d got dm_ack=%b if_ack=%b gap=%0d required dm_ack=%b gap=%0d",
                             acks, bus.dm_ack, bus.if_ack, cyc - last_cyc, exp_dm_win, WS + 2);
                end
                n_checks++;
                if (exp_dm_win ? (bus.dm_rdata !== ref_mem[widx(da)]) : (bus.if_rdata !== ref_mem[widx(ia)])) begin
                    n_fail++;
                    $display("FAIL rr_rdata n=%0d got if=%h dm=%h required if=%h dm=%h", acks,
                             bus.if_rdata, bus.dm_rdata, ref_mem[widx(ia)], ref_mem[widx(da)]);
                end
                model_last_dm = exp_dm_win;
                last_cyc = cyc;
                acks++;
                if (acks == 8) begin
                    @(negedge clk); bus.if_req = 0; bus.dm_req = 0;
                end
            end
        end
        if (acks < 8) begin
            n_checks++; n_fail++;
            $display("FAIL rr_timeout got %0d acks required 8", acks);
            @(negedge clk); bus.if_req = 0; bus.dm_req = 0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_rst_mid_write();
        logic [31:0] da;
        da = 32'h0000_0300;
        @(negedge clk);
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'hF; bus.dm_addr = da; bus.dm_wdata = ref_mem[widx(da)];
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.sram_we_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre_we got we_n=%b required 0", bus.sram_we_n);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.sram_we_n !== 1'b1 || bus.sram_ce_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 || bus.sram_be_n !== 4'hF ||
            bus.sram_addr !== '0 || bus.sram_dq_o !== 32'h0 || bus.dm_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort got we_n=%b ce_n=%b dq_oe=%b be_n=%b addr=%h dq=%h ack=%b required 1 1 0 1111 0 0 0",
                     bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe, bus.sram_be_n, bus.sram_addr,
                     bus.sram_dq_o, bus.dm_ack);
        end
        @(negedge clk); rst = 1'b0; bus.dm_req = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.dm_ack !== 1'b0 || bus.sram_ce_n !== 1'b1) begin
                n_fail++; $display("FAIL rst_no_ack got ack=%b ce_n=%b required 0 1", bus.dm_ack, bus.sram_ce_n);
            end
        end
        model_last_dm = 1'b0;
        run_txn(1, 0, 0, 4'h0, 32'h0000_0040, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int k;
        k = 0;
        @(negedge clk); bus0.if_req = 1; bus0.if_addr = 32'h0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cyc % 2 == 1) begin
                if (bus0.sram_ce_n !== 1'b0 || bus0.sram_oe_n !== 1'b0 || bus0.sram_addr !== ADDR_W'(k) ||
                    bus0.if_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_strobe cyc=%0d got ce_n=%b oe_n=%b addr=%h ack=%b required 0 0 %0d 0",
                             cyc, bus0.sram_ce_n, bus0.sram_oe_n, bus0.sram_addr, bus0.if_ack, k);
                end
            end else begin
                if (bus0.if_ack !== 1'b1 || bus0.if_rdata !== (32'hC0DE_0000 | 32'(k))) begin
                    n_fail++;
                    $display("FAIL b2b_ack cyc=%0d got ack=%b rdata=%h required 1 %h",
                             cyc, bus0.if_ack, bus0.if_rdata, 32'hC0DE_0000 | 32'(k));
                end
                k++;
                @(negedge clk);
                if (k < 3) bus0.if_addr = 32'(4 * k);
                else       bus0.if_req  = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int sel, gap;
        logic [31:0] ia, da, wd;
        logic [3:0] be;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            ia = $urandom; ia[19:12] = '0;
            da = $urandom; da[19:12] = '0;
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            case (sel)
                0:       run_txn(1, 0, 0, 4'hF, ia, da, wd);
                1:       run_txn(0, 1, 0, 4'hF, ia, da, wd);
                2:       run_txn(0, 1, 1, be, ia, da, wd);
                default: run_txn(1, 1, 1'($urandom_range(0, 1)), be, ia, da, wd);
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h2402_000A;
        ref_mem[4] = 32'h2402_000A;
        repeat (3) @(posedge clk);
        test_reset();
        test_fetch();
        test_write();
        test_priority();
        test_rr();
        test_rst_mid_write();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external asynchronous SRAM between the instruction-fetch port and the data-memory port.
- Sequences each SRAM access through a multi-cycle read/write state machine with configurable wait states and a write-recovery turnaround.
- Generates the per-port stall that holds the PC (fetch pcwe input) and the MEM stage until the access completes.

Parameters:
- ADDR_W, 18, SRAM word-address width; byte address bits [ADDR_W+1:2] are used, all other bits are ignored.
- WAIT_STATES, 1, extra cycles each SRAM strobe is held beyond the first; legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address (PC)
- if_rdata  out  32  fetched instruction; registered; valid with if_ack and held until the next fetch completes
- if_ack  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_ack; drives the fetch pcwe input
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  4  byte enables, active-high
- dm_addr  in  32  data byte address
- dm_wdata  in  32  write data
- dm_rdata  out  32  read data; registered; valid with dm_ack
- dm_ack  out  1  one-cycle completion pulse
- dm_stall  out  1  dm_req & ~dm_ack
- sram_addr  out  ADDR_W  SRAM word address
- sram_dq_o  out  32  SRAM write data
- sram_dq_oe  out  1  SRAM data-pin output enable (1 = drive)
- sram_dq_i  in  32  SRAM read data
- sram_ce_n  out  1  SRAM chip enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_we_n  out  1  SRAM write enable, active-low
- sram_be_n  out  4  SRAM byte lanes, active-low

Behaviour:
- Reset values:
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_be_n = 4'hF; sram_dq_oe = 0.
  - sram_addr, sram_dq_o, if_rdata, dm_rdata = 0; if_ack, dm_ack = 0.
  - FSM = IDLE; wait counter = 0.
- States:
  - IDLE: request arbitration only.
  - RD: SRAM read strobe, used for fetches and data reads.
  - WR: SRAM write strobe.
  - TURN: one-cycle write-recovery turnaround.
- All SRAM outputs are registered.
- IDLE arbitration:
  - If dm_req, latch address/be/wdata and go to RD (dm_we = 0) or WR (dm_we = 1). Owner = DM.
  - Else if if_req, latch if_addr and go to RD with be_n = 0. Owner = IF.
  - Without RR_EN, data has fixed priority over fetch.
- RD:
  - ce_n = 0, oe_n = 0, dq_oe = 0.
  - The counter runs 0..WAIT_STATES.
  - When the counter equals WAIT_STATES, sram_dq_i is captured into the owner's rdata, the owner's ack is set for the next cycle, and the FSM goes to IDLE.
- WR:
  - ce_n = 0, we_n = 0, dq_oe = 1, be_n = ~dm_be.
  - After WAIT_STATES+1 cycles, go to TURN.
- TURN:
  - we_n = 1, ce_n = 1, dq_oe = 1 (data hold), oe_n = 1.
  - dm_ack is set for the next cycle; go to IDLE.
- Latency from the first cycle req is seen in IDLE to the ack cycle:
  - Read: WAIT_STATES+2 cycles.
  - Write: WAIT_STATES+3 cycles.
- The ack cycle is an IDLE cycle, so arbitration occurs in it. A req still high in the ack cycle is a new request; requesters must drop or update req in that cycle.
- If req drops mid-access, the access still completes and the ack still pulses.
- Simultaneous if_req and dm_req: DM is served first; IF remains stalled until its turn.
- Address bits outside [ADDR_W+1:2] are ignored, so addresses wrap modulo the SRAM size.
- rst asserted mid-access: the access aborts at the next edge; all outputs return to reset values; no ack is issued.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined:
  - A one-bit last-owner register (reset = IF) is added.
  - When both requests are present in IDLE, the port that was not the last owner wins.
  - A single requester always wins.
- Undefined: fixed data-over-fetch priority, with no last-owner register.

Test Plan:
1. WAIT_STATES=1, if_req=1, if_addr=0x10, SRAM model returns 0x2402000A at word 4 -> sram_addr=4 with oe_n/ce_n low for 2 cycles; if_ack pulses on cycle 3; if_rdata=0x2402000A; if_stall high cycles 1-2.
2. dm write to 0x20 with dm_be=4'b0011 and dm_wdata=0xDEADBEEF -> we_n low 2 cycles with be_n=4'b1100; then a TURN cycle with dq_oe=1; dm_ack on cycle 4. A follow-up read of 0x20 returns the model's value 0x????BEEF.
3. if_req and dm_req (read) raised in the same cycle, fixed priority -> DM served first with dm_ack at cycle 3; IF served next with if_ack at cycle 6; if_stall stays high through cycle 5.
4. SRAM_ARB_RR_EN defined, both ports requesting continuously for 8 accesses -> grants alternate IF, DM, IF, DM... after the first grant.
5. rst pulsed during the second cycle of a WR -> next cycle we_n=1, ce_n=1, dq_oe=0, no dm_ack; FSM in IDLE; a new request is accepted afterwards.
6. WAIT_STATES=0 back-to-back fetches of 0x0, 0x4, 0x8 with req held high -> if_ack every 2 cycles; sram_addr sequence 0, 1, 2.
